// File: rtl/cam_dvp_capture_if.sv
// DVP capture bundle: camera byte bus in, expanded pixel stream and frame status out.
// The master side is the capture core that produces the pixel stream.
interface cam_dvp_capture_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              i_vsync;
    logic              i_href;
    logic [7:0]        i_data;
    logic [7:0]        o_red;
    logic [7:0]        o_green;
    logic [7:0]        o_blue;
    logic [ADDR_W-1:0] o_address;
    logic              o_valid;
    logic              o_start_frame;
    logic              o_frame_done;
    logic              o_frame_err;

    modport master (
        input  i_vsync, i_href, i_data,
        output o_red, o_green, o_blue, o_address,
        output o_valid, o_start_frame, o_frame_done, o_frame_err
    );

    modport slave (
        output i_vsync, i_href, i_data,
        input  o_red, o_green, o_blue, o_address,
        input  o_valid, o_start_frame, o_frame_done, o_frame_err
    );
endinterface

// File: rtl/cam_dvp_capture.sv
// OV7670-style DVP capture: rebuilds RGB565 pixels from byte pairs, expands to RGB888,
// tracks a linear frame-buffer address and reports per-frame geometry errors.
module cam_dvp_capture #(
    parameter int unsigned HPIXELS = 640,
    parameter int unsigned VPIXELS = 480,
    parameter int unsigned ADDR_W  = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    cam_dvp_capture_if.master bus
);
    localparam int unsigned COL_W = $clog2(HPIXELS + 2);
    localparam int unsigned ROW_W = $clog2(VPIXELS + 2);
    localparam logic [COL_W-1:0] COL_FULL = COL_W'(HPIXELS);
    localparam logic [COL_W-1:0] COL_SAT  = COL_W'(HPIXELS + 1);
    localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(VPIXELS);
    localparam logic [ROW_W-1:0] ROW_SAT  = ROW_W'(VPIXELS + 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(VPIXELS - 1);

    typedef enum logic [1:0] {WAIT_VS, IDLE_LINE, BYTE_HI, BYTE_LO} state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_vs_d;
    logic [7:0]        r_hi;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_base;
    logic              r_err;
    logic              r_done_pend;

    logic [7:0]        r_red;
    logic [7:0]        r_green;
    logic [7:0]        r_blue;
    logic [ADDR_W-1:0] r_address;
    logic              r_valid;
    logic              r_sof;
    logic              r_frame_done;
    logic              r_frame_err;

    logic              w_vs_fall;
    logic              w_vs_rise;
    logic              w_sof;
    logic              w_latch_hi;
    logic              w_fire;
    logic              w_odd;
    logic              w_eol;
    logic              w_eof;
    logic              w_eof_pend;
    logic              w_pix_ok;
    logic [COL_W-1:0]  w_col_inc;
    logic [ROW_W-1:0]  w_row_inc;
    logic [COL_W-1:0]  w_col_after;
    logic [ROW_W-1:0]  w_row_after;
    logic              w_err_set;
    logic              w_err_next;
    logic [15:0]       w_pixel;
    logic [ADDR_W-1:0] w_base_next;

    assign w_vs_fall = r_vs_d & ~bus.i_vsync;
    assign w_vs_rise = ~r_vs_d & bus.i_vsync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= WAIT_VS;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_VS: begin
                if (w_vs_fall && !r_done_pend) w_state_next = IDLE_LINE;
            end
            IDLE_LINE: begin
                if (w_vs_rise)        w_state_next = WAIT_VS;
                else if (bus.i_href)  w_state_next = BYTE_LO;
            end
            BYTE_HI: begin
                if (w_vs_rise)        w_state_next = WAIT_VS;
                else if (bus.i_href)  w_state_next = BYTE_LO;
                else                  w_state_next = IDLE_LINE;
            end
            BYTE_LO: begin
                if (w_vs_rise)        w_state_next = WAIT_VS;
                else if (bus.i_href)  w_state_next = BYTE_HI;
                else                  w_state_next = IDLE_LINE;
            end
            default: w_state_next = WAIT_VS;
        endcase
    end

    // A low byte arriving with the VSYNC rise still emits its pixel; frame_done is deferred one cycle.
    always_comb begin
        w_sof      = 1'b0;
        w_latch_hi = 1'b0;
        w_fire     = 1'b0;
        w_odd      = 1'b0;
        w_eol      = 1'b0;
        w_eof      = 1'b0;
        w_eof_pend = 1'b0;
        case (r_state)
            WAIT_VS: begin
                w_sof = w_vs_fall & ~r_done_pend;
            end
            IDLE_LINE: begin
                if (w_vs_rise)        w_eof = 1'b1;
                else if (bus.i_href)  w_latch_hi = 1'b1;
            end
            BYTE_HI: begin
                if (w_vs_rise) begin
                    w_eol = 1'b1;
                    w_eof = 1'b1;
                end else if (bus.i_href) begin
                    w_latch_hi = 1'b1;
                end else begin
                    w_eol = 1'b1;
                end
            end
            BYTE_LO: begin
                if (bus.i_href) begin
                    w_fire = 1'b1;
                    if (w_vs_rise) begin
                        w_eol      = 1'b1;
                        w_eof_pend = 1'b1;
                    end
                end else begin
                    w_odd = 1'b1;
                    w_eol = 1'b1;
                    w_eof = w_vs_rise;
                end
            end
            default: ;
        endcase
    end

    assign w_pixel     = {r_hi, bus.i_data};
    assign w_pix_ok    = (r_col < COL_FULL) && (r_row < ROW_FULL);
    assign w_col_inc   = (r_col == COL_SAT) ? r_col : r_col + 1'b1;
    assign w_row_inc   = (r_row == ROW_SAT) ? r_row : r_row + 1'b1;
    assign w_col_after = w_fire ? w_col_inc : r_col;
    assign w_row_after = w_eol ? w_row_inc : r_row;
    assign w_base_next = (r_row < ROW_LAST) ? r_base + ADDR_W'(HPIXELS) : r_base;

    // Column/row checks use the post-event counts so a closing pixel or line is included.
    assign w_err_set = (w_fire && !w_pix_ok) || w_odd
                     || (w_eol && (w_col_after != COL_FULL))
                     || ((w_eof || w_eof_pend) && (w_row_after != ROW_FULL));
    assign w_err_next = w_sof ? 1'b0 : (r_err | w_err_set);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vs_d       <= 1'b0;
            r_hi         <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_base       <= '0;
            r_err        <= 1'b0;
            r_done_pend  <= 1'b0;
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
            r_address    <= '0;
            r_valid      <= 1'b0;
            r_sof        <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_vs_d       <= bus.i_vsync;
            r_sof        <= w_sof;
            r_valid      <= w_fire & w_pix_ok;
            r_frame_done <= w_eof | r_done_pend;
            r_done_pend  <= w_eof_pend;
            r_err        <= w_err_next;

            if (w_eof) begin
                r_frame_err <= w_err_next;
            end else if (r_done_pend) begin
                r_frame_err <= r_err;
            end

            if (w_latch_hi) begin
                r_hi <= bus.i_data;
            end

            if (w_fire && w_pix_ok) begin
                r_red     <= {w_pixel[15:11], w_pixel[15:13]};
                r_green   <= {w_pixel[10:5], w_pixel[10:9]};
                r_blue    <= {w_pixel[4:0], w_pixel[4:2]};
                r_address <= r_addr;
            end

            if (w_sof) begin
                r_col  <= '0;
                r_row  <= '0;
                r_addr <= '0;
                r_base <= '0;
            end else if (w_eol) begin
                r_col  <= '0;
                r_row  <= w_row_inc;
                r_base <= w_base_next;
                r_addr <= w_base_next;
            end else if (w_fire) begin
                r_col <= w_col_inc;
                if (w_pix_ok) r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign bus.o_red         = r_red;
    assign bus.o_green       = r_green;
    assign bus.o_blue        = r_blue;
    assign bus.o_address     = r_address;
    assign bus.o_valid       = r_valid;
    assign bus.o_start_frame = r_sof;
    assign bus.o_frame_done  = r_frame_done;
    assign bus.o_frame_err   = r_frame_err;
endmodule

// File: tb/tb_cam_dvp_capture.sv
// Directed bench for cam_dvp_capture on a reduced 8x4 frame: expansion table, geometry
// errors, reset recovery and the VSYNC/low-byte coincidence.
module tb_cam_dvp_capture;
    localparam int unsigned HPIXELS = 8;
    localparam int unsigned VPIXELS = 4;
    localparam int unsigned ADDR_W  = 20;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_valid;
    int   n_sof;
    int   n_done;
    int   cur_row;
    int   v0;
    int   s0;
    int   d0;
    rgb_vec_t vec [8];

    cam_dvp_capture_if #(.ADDR_W(ADDR_W)) bus ();

    cam_dvp_capture #(
        .HPIXELS (HPIXELS),
        .VPIXELS (VPIXELS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp5(input logic [4:0] v);
        logic [7:0] t;
        t = 8'(v);
        return (t << 3) | (t >> 2);
    endfunction

    function automatic logic [7:0] exp6(input logic [5:0] v);
        logic [7:0] t;
        t = 8'(v);
        return (t << 2) | (t >> 4);
    endfunction

    function automatic logic [15:0] pat(input int row, input int col);
        if (row == 2 && col == 5) return 16'hF800;
        return 16'(row * 4099 + col * 263 + 16'h1357);
    endfunction

    task automatic step(input logic vs, input logic hr, input logic [7:0] d);
        bus.i_vsync = vs;
        bus.i_href  = hr;
        bus.i_data  = d;
        @(posedge clk);
        #1;
        if (bus.o_valid)       n_valid++;
        if (bus.o_start_frame) n_sof++;
        if (bus.o_frame_done)  n_done++;
        check("valid_with_sof", 32'(bus.o_valid & bus.o_start_frame), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_red"},   32'(bus.o_red), 32'd0);
        check({tag, "_green"}, 32'(bus.o_green), 32'd0);
        check({tag, "_blue"},  32'(bus.o_blue), 32'd0);
        check({tag, "_addr"},  32'(bus.o_address), 32'd0);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        check({tag, "_sof"},   32'(bus.o_start_frame), 32'd0);
        check({tag, "_done"},  32'(bus.o_frame_done), 32'd0);
        check({tag, "_err"},   32'(bus.o_frame_err), 32'd0);
    endtask

    task automatic frame_start();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("sof_pulse", 32'(bus.o_start_frame), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        check("sof_one_cycle", 32'(bus.o_start_frame), 32'd0);
        cur_row = 0;
    endtask

    task automatic send_pixel(input int c, input logic vs_lo);
        logic [15:0] p;
        logic        exp_v;
        p = pat(cur_row, c);
        step(1'b0, 1'b1, p[15:8]);
        check("hi_no_valid", 32'(bus.o_valid), 32'd0);
        step(vs_lo, 1'b1, p[7:0]);
        exp_v = (c < HPIXELS) && (cur_row < VPIXELS);
        check("pix_valid", 32'(bus.o_valid), 32'(exp_v));
        if (exp_v) begin
            check("pix_addr",  32'(bus.o_address), 32'(cur_row * HPIXELS + c));
            check("pix_red",   32'(bus.o_red),   32'(exp5(p[15:11])));
            check("pix_green", 32'(bus.o_green), 32'(exp6(p[10:5])));
            check("pix_blue",  32'(bus.o_blue),  32'(exp5(p[4:0])));
        end
        if (exp_v && cur_row == 2 && c == 5) begin
            check("r2c5_addr",  32'(bus.o_address), 32'd21);
            check("r2c5_red",   32'(bus.o_red),   32'hFF);
            check("r2c5_green", 32'(bus.o_green), 32'h00);
            check("r2c5_blue",  32'(bus.o_blue),  32'h00);
        end
    endtask

    task automatic send_line(input int npix, input bit odd);
        for (int c = 0; c < npix; c++) send_pixel(c, 1'b0);
        if (odd) step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 8'h00);
        cur_row++;
    endtask

    task automatic end_frame(input logic exp_err);
        step(1'b1, 1'b0, 8'h00);
        check("frame_done", 32'(bus.o_frame_done), 32'd1);
        check("frame_err", 32'(bus.o_frame_err), 32'(exp_err));
        step(1'b1, 1'b0, 8'h00);
        check("frame_done_pulse", 32'(bus.o_frame_done), 32'd0);
    endtask

    initial begin
        vec[0] = '{hi: 8'h84, lo: 8'h10, r: 8'h84, g: 8'h82, b: 8'h84};
        vec[1] = '{hi: 8'hF8, lo: 8'h00, r: 8'hFF, g: 8'h00, b: 8'h00};
        vec[2] = '{hi: 8'h07, lo: 8'hE0, r: 8'h00, g: 8'hFF, b: 8'h00};
        vec[3] = '{hi: 8'h00, lo: 8'h1F, r: 8'h00, g: 8'h00, b: 8'hFF};
        vec[4] = '{hi: 8'hFF, lo: 8'hFF, r: 8'hFF, g: 8'hFF, b: 8'hFF};
        vec[5] = '{hi: 8'h00, lo: 8'h00, r: 8'h00, g: 8'h00, b: 8'h00};
        vec[6] = '{hi: 8'h08, lo: 8'h41, r: 8'h08, g: 8'h08, b: 8'h08};
        vec[7] = '{hi: 8'hA5, lo: 8'h5A, r: 8'hA5, g: 8'hAA, b: 8'hD6};

        n_checks = 0; n_fail = 0; n_valid = 0; n_sof = 0; n_done = 0; cur_row = 0;
        rst = 1'b1;
        bus.i_vsync = 1'b0; bus.i_href = 1'b0; bus.i_data = 8'h00;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        check_zero("reset");
        rst = 1'b0;

        // Reset in the middle of an active line
        frame_start();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'h40 + i));
        rst = 1'b1;
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        check_zero("rst_midline");
        rst = 1'b0;
        v0 = n_valid; s0 = n_sof; d0 = n_done;
        step(1'b0, 1'b1, 8'h33);
        check_zero("after_rst");
        repeat (6) step(1'b0, 1'b1, 8'hC3);
        step(1'b0, 1'b0, 8'h00);
        check("no_valid_before_sof", 32'(n_valid - v0), 32'd0);
        frame_start();
        check("sof_once", 32'(n_sof - s0), 32'd1);
        check("no_done_lost_frame", 32'(n_done - d0), 32'd0);

        // Clean frame including pixel (2,5) = F800
        for (int r = 0; r < VPIXELS; r++) send_line(HPIXELS, 1'b0);
        end_frame(1'b0);

        // Expansion table on row 0, one-cycle latency after the low byte
        frame_start();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, vec[i].hi);
            check("tbl_hi_no_valid", 32'(bus.o_valid), 32'd0);
            step(1'b0, 1'b1, vec[i].lo);
            check("tbl_valid", 32'(bus.o_valid), 32'd1);
            check("tbl_addr",  32'(bus.o_address), 32'(i));
            check("tbl_red",   32'(bus.o_red),   32'(vec[i].r));
            check("tbl_green", 32'(bus.o_green), 32'(vec[i].g));
            check("tbl_blue",  32'(bus.o_blue),  32'(vec[i].b));
        end
        step(1'b0, 1'b0, 8'h00);
        check("tbl_no_valid_after_eol", 32'(bus.o_valid), 32'd0);
        cur_row = 1;
        for (int r = 1; r < VPIXELS; r++) send_line(HPIXELS, 1'b0);
        end_frame(1'b0);

        // One line one pixel too long; error held until next frame_done
        frame_start();
        send_line(HPIXELS, 1'b0);
        send_line(HPIXELS + 1, 1'b0);
        send_line(HPIXELS, 1'b0);
        send_line(HPIXELS, 1'b0);
        end_frame(1'b1);
        repeat (3) step(1'b1, 1'b0, 8'h00);
        check("err_held", 32'(bus.o_frame_err), 32'd1);
        check("err_held_no_done", 32'(bus.o_frame_done), 32'd0);
        frame_start();
        for (int r = 0; r < VPIXELS; r++) send_line(HPIXELS, 1'b0);
        end_frame(1'b0);

        // Odd byte count on row 1
        frame_start();
        send_line(HPIXELS, 1'b0);
        v0 = n_valid;
        send_line(HPIXELS - 1, 1'b1);
        check("odd_pixel_count", 32'(n_valid - v0), 32'(HPIXELS - 1));
        send_line(HPIXELS, 1'b0);
        send_line(HPIXELS, 1'b0);
        end_frame(1'b1);

        // Short frame, then no output until the next start
        frame_start();
        send_line(HPIXELS, 1'b0);
        send_line(HPIXELS, 1'b0);
        end_frame(1'b1);
        v0 = n_valid; s0 = n_sof;
        repeat (6) step(1'b1, 1'b1, 8'hAA);
        step(1'b1, 1'b0, 8'h00);
        check("short_no_valid", 32'(n_valid - v0), 32'd0);
        check("short_no_sof", 32'(n_sof - s0), 32'd0);
        frame_start();

        // Last low byte coincides with the VSYNC rise
        for (int r = 0; r < VPIXELS - 1; r++) send_line(HPIXELS, 1'b0);
        for (int c = 0; c < HPIXELS - 1; c++) send_pixel(c, 1'b0);
        send_pixel(HPIXELS - 1, 1'b1);
        check("coinc_addr_last", 32'(bus.o_address), 32'(HPIXELS * VPIXELS - 1));
        check("coinc_done_not_yet", 32'(bus.o_frame_done), 32'd0);
        step(1'b1, 1'b0, 8'h00);
        check("coinc_done", 32'(bus.o_frame_done), 32'd1);
        check("coinc_err", 32'(bus.o_frame_err), 32'd0);
        check("coinc_valid_low", 32'(bus.o_valid), 32'd0);
        step(1'b1, 1'b0, 8'h00);
        check("coinc_done_pulse", 32'(bus.o_frame_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_dvp_capture.md
Name: cam_dvp_capture

Overview:
- Capture front end that produces the pixel stream consumed by the VGA output block.
- Samples an OV7670-style DVP camera bus (VSYNC, HREF, 8-bit data, RGB565, two bytes per pixel) on the camera pixel clock.
- Reassembles each pixel and expands it to 8-bit R/G/B.
- Emits each pixel with a linear frame-buffer address, a one-cycle start-of-frame pulse and per-frame integrity status.

Parameters:
- HPIXELS, 640, active pixels per line
- VPIXELS, 480, active lines per frame
- ADDR_W, 20, address width; HPIXELS*VPIXELS-1 must fit

Ports:
- i_clk  in  1  camera pixel clock; all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_vsync  in  1  camera VSYNC; high = vertical blanking
- i_href  in  1  camera HREF; high = valid data byte this cycle
- i_data  in  8  camera data byte
- o_red  out  8  expanded red
- o_green  out  8  expanded green
- o_blue  out  8  expanded blue
- o_address  out  ADDR_W  row*HPIXELS+col of current pixel
- o_valid  out  1  pixel outputs valid this cycle
- o_start_frame  out  1  one-cycle pulse at frame start
- o_frame_done  out  1  one-cycle pulse at frame end
- o_frame_err  out  1  status of last completed frame; valid with o_frame_done, held until next o_frame_done

Behaviour:
- Reset (i_rst=1 at rising edge):
  - All outputs go to 0.
  - Counters go to 0.
  - State goes to WAIT_VS.
  - A reset mid-frame discards that frame. Capture resumes only after a fresh VSYNC falling edge.
- Input registering: i_vsync is registered once (vs_d) for edge detection. i_href and i_data are used as sampled.
- States:
  - WAIT_VS: ignore data. vs_d=1 and i_vsync=0 (falling edge) -> IDLE_LINE. Next cycle: o_start_frame=1, row=0, col=0, error flag cleared.
  - IDLE_LINE:
    - i_href=1 -> latch i_data as high byte, go to BYTE_LO.
    - i_vsync rising edge -> end of frame (see below), go to WAIT_VS.
  - BYTE_HI: i_href=1 -> latch high byte, go to BYTE_LO. i_href=0 -> end of line.
  - BYTE_LO:
    - i_href=1 -> form pixel {hi,i_data}, go to BYTE_HI.
    - i_href=0 -> odd byte count: set error flag, then end of line.
- Pixel output, registered, 1 cycle after the low byte is presented:
  - o_valid=1 only if col<HPIXELS and row<VPIXELS; otherwise the pixel is dropped and the error flag is set.
  - RGB565 expansion with MSB replication:
    - o_red = {R[4:0],R[4:2]}
    - o_green = {G[5:0],G[5:4]}
    - o_blue = {B[4:0],B[4:2]}
  - o_address is computed incrementally, no multiplier: +1 per pixel; line base += HPIXELS per completed line.
  - col increments after every formed pixel.
- End of line (HREF falls):
  - If col != HPIXELS, set the error flag.
  - row += 1, col = 0, address = new line base; go to IDLE_LINE.
  - A line with zero bytes is not possible, since HREF must rise first.
- End of frame (VSYNC rises in IDLE_LINE, BYTE_HI or BYTE_LO):
  - If in BYTE_HI/BYTE_LO with HREF still high, treat as end of line first (including the col check).
  - If row != VPIXELS after that, set the error flag.
  - Next cycle: o_frame_done=1 and o_frame_err = error flag.
  - Go to WAIT_VS.
  - o_frame_done never fires for a frame whose start was not seen.
- Simultaneous events:
  - A low byte and a VSYNC rise in the same cycle: the pixel is still emitted, and o_frame_done follows it by 1 cycle.
  - o_valid is never asserted in the same cycle as o_start_frame.
- Address wrap: never wraps; the last legal address is HPIXELS*VPIXELS-1, and excess pixels are dropped per the rule above.

Test Plan:
- Reset during an active line, then release: all outputs 0. Data bytes before the next VSYNC falling edge produce no o_valid. After the falling edge, o_start_frame pulses exactly once.
- Full 640x480 frame, pixel (row 2, col 5) = 0xF800: o_valid with o_address=1285, o_red=0xFF, o_green=0x00, o_blue=0x00. o_frame_done=1 with o_frame_err=0 after VSYNC rises.
- Pixel bytes 0x84,0x10 (R=16,G=32,B=16): o_red=0x84, o_green=0x82, o_blue=0x84, exactly 1 cycle after byte 0x10.
- Line with 641 pixels: the 641st is not valid; o_frame_err=1 at frame end. Next clean frame reports o_frame_err=0.
- Line with odd byte count (1279 bytes): 639 pixels emitted; o_frame_err=1. Next line starts at address line_base+640.
- VSYNC rises after 100 lines: o_frame_done pulses with o_frame_err=1. No o_valid until the next o_start_frame.
